// File: rtl/hack_bus_pkg.sv
// ============================================================================
// Module  : hack_bus_pkg
// Brief   : Shared Hack data-bus widths, MMIO addresses and arbiter state codes
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_bus_pkg;

  localparam int HACK_AW = 16;
  localparam int HACK_DW = 16;

  // Memory-mapped peripherals live above the 16K RAM window.
  localparam logic [15:0] ADDR_LED  = 16'd16384;
  localparam logic [15:0] ADDR_PMOD = 16'd16385;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_OWN0 = 2'd1;
  localparam arb_state_t ARB_OWN1 = 2'd2;

  // Width needed to hold a beat count in 0..max_burst.
  function automatic int burst_cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_grant_logic.sv
// ============================================================================
// Module  : arb_grant_logic
// Brief   : Combinational burst-fair grant selection between two requesters
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant_logic
  import hack_bus_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = 3
) (
  input  logic          req0_i,
  input  logic          req1_i,
  input  arb_state_t    state_i,
  input  logic [CW-1:0] burst_cnt_i,
  output logic          gnt0_o,
  output logic          gnt1_o
);

  logic burst_full;

  assign burst_full = (burst_cnt_i >= CW'(MAX_BURST));

  // Lone requester always wins; under contention the owner keeps the port until its burst is used up.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && !req1_i) begin
      gnt0_o = 1'b1;
    end else if (req1_i && !req0_i) begin
      gnt1_o = 1'b1;
    end else if (req0_i && req1_i) begin
      case (state_i)
        ARB_OWN0: begin
          gnt0_o = !burst_full;
          gnt1_o = burst_full;
        end
        ARB_OWN1: begin
          gnt1_o = !burst_full;
          gnt0_o = burst_full;
        end
        default: gnt0_o = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares the Hack data-memory port between the CPU (m0) and the
//           UART loader (m1) with burst-fair arbitration and 1-cycle reads
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import hack_bus_pkg::*;
#(
  parameter int AW        = HACK_AW,
  parameter int DW        = HACK_DW,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in,
  output logic          mem_load,
  input  logic [DW-1:0] mem_out
);

  localparam int CW = burst_cnt_width(MAX_BURST);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          raw_gnt0, raw_gnt1;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;
  logic          m0_rvalid_q, m1_rvalid_q;

  arb_grant_logic #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_grant (
    .req0_i      (m0_req),
    .req1_i      (m1_req),
    .state_i     (state_q),
    .burst_cnt_i (burst_cnt_q),
    .gnt0_o      (raw_gnt0),
    .gnt1_o      (raw_gnt1)
  );

  // No grant may escape while reset is asserted, even though the FSM is already IDLE.
  assign m0_gnt = raw_gnt0 & rst_n;
  assign m1_gnt = raw_gnt1 & rst_n;

  // Track the owner of the last beat and its run length; an idle cycle ends the burst.
  always_comb begin
    state_d     = ARB_IDLE;
    burst_cnt_d = '0;
    if (m0_gnt || m1_gnt) begin
      state_d = m0_gnt ? ARB_OWN0 : ARB_OWN1;
      if (state_d != state_q) begin
        burst_cnt_d = CW'(1);
      end else if (burst_cnt_q >= CW'(MAX_BURST)) begin
        burst_cnt_d = CW'(MAX_BURST);
      end else begin
        burst_cnt_d = burst_cnt_q + CW'(1);
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Steer the granted requester onto the memory port; drive zeros when nobody owns it.
  always_comb begin
    mem_address = '0;
    mem_in      = '0;
    if (m0_gnt) begin
      mem_address = m0_addr;
      mem_in      = m0_wdata;
    end else if (m1_gnt) begin
      mem_address = m1_addr;
      mem_in      = m1_wdata;
    end
  end

  assign mem_load = (m0_gnt & m0_we) | (m1_gnt & m1_we);

  // Capture combinational read data at the grant edge; rdata holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      m0_rvalid_q <= m0_gnt & ~m0_we;
      m1_rvalid_q <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata_q <= mem_out;
      if (m1_gnt && !m1_we) m1_rdata_q <= mem_out;
    end
  end

  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Self-checking bench for mem_bus_arbiter against a behavioural model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic [15:0] adr [2];
  logic [15:0] wd  [2];
  logic        we  [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_load;
  logic [15:0] m0_rdata, m1_rdata, mem_address, mem_in, mem_out;

  // Memory behind the port, plus a tally of writes hitting 16'h0010.
  logic [15:0] ram [0:65535];
  int          wr10_cnt = 0;
  logic [15:0] wr10_val = '0;

  // Model state: memory image, history of winners (-1 = idle cycle), expected read returns.
  logic [15:0] ref_mem [0:65535];
  int          hist[$];
  logic        exp_rv [2];
  logic [15:0] exp_rd [2];

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(.AW(16), .DW(16), .MAX_BURST(MAXB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (req[0]),
    .m0_addr     (adr[0]),
    .m0_wdata    (wd[0]),
    .m0_we       (we[0]),
    .m0_gnt      (m0_gnt),
    .m0_rdata    (m0_rdata),
    .m0_rvalid   (m0_rvalid),
    .m1_req      (req[1]),
    .m1_addr     (adr[1]),
    .m1_wdata    (wd[1]),
    .m1_we       (we[1]),
    .m1_gnt      (m1_gnt),
    .m1_rdata    (m1_rdata),
    .m1_rvalid   (m1_rvalid),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  always #5 clk = ~clk;

  assign mem_out = ram[mem_address];

  always @(posedge clk) begin
    if (mem_load) begin
      ram[mem_address] = mem_in;
      if (mem_address == 16'h0010) begin
        wr10_cnt = wr10_cnt + 1;
        wr10_val = mem_in;
      end
    end
  end

  task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Who should win this cycle: lone requester wins; contention goes to m0 after
  // an idle cycle, else the last winner until it has MAXB back-to-back beats.
  function automatic int model_pick();
    int last, streak;
    if (!req[0] && !req[1]) return -1;
    if (req[0] && !req[1]) return 0;
    if (req[1] && !req[0]) return 1;
    if (hist.size() == 0) return 0;
    last = hist[$];
    if (last < 0) return 0;
    streak = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != last) break;
      streak++;
    end
    return (streak < MAXB) ? last : 1 - last;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int x = 0; x < 2; x++) begin
      exp_rv[x] = 1'b0;
      exp_rd[x] = '0;
    end
  endfunction

  // One bus cycle: called just after a negedge with inputs already driven.
  task automatic step(output int win);
    logic [15:0] ea, ed;
    logic        el;
    #1;
    win = model_pick();
    ea  = (win >= 0) ? adr[win] : 16'h0000;
    ed  = (win >= 0) ? wd[win]  : 16'h0000;
    el  = (win >= 0) ? we[win]  : 1'b0;
    chk_value("gnt0", m0_gnt, win == 0);
    chk_value("gnt1", m1_gnt, win == 1);
    chk_value("mem_address", mem_address, ea);
    chk_value("mem_in", mem_in, ed);
    chk_value("mem_load", mem_load, el);
    hist.push_back(win);
    if (hist.size() > 16) void'(hist.pop_front());
    for (int x = 0; x < 2; x++) begin
      exp_rv[x] = (win == x) && !we[x];
      if (exp_rv[x]) exp_rd[x] = ref_mem[adr[x]];
    end
    if (win >= 0 && we[win]) ref_mem[adr[win]] = wd[win];
    @(negedge clk);
    chk_value("rvalid0", m0_rvalid, exp_rv[0]);
    chk_value("rvalid1", m1_rvalid, exp_rv[1]);
    chk_value("rdata0", m0_rdata, exp_rd[0]);
    chk_value("rdata1", m1_rdata, exp_rd[1]);
  endtask

  task automatic set_req(input int x, input logic w, input logic [15:0] a, input logic [15:0] d);
    req[x] = 1'b1;
    we[x]  = w;
    adr[x] = a;
    wd[x]  = d;
  endtask

  task automatic idle_reqs();
    req[0] = 1'b0;
    req[1] = 1'b0;
  endtask

  initial begin
    int win;
    int got_m1;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'(i) ^ 16'h5A3C;
      ref_mem[i] = 16'(i) ^ 16'h5A3C;
    end
    ram[5]     = 16'hBEEF;
    ref_mem[5] = 16'hBEEF;
    for (int x = 0; x < 2; x++) begin
      req[x] = 1'b0; adr[x] = '0; wd[x] = '0; we[x] = 1'b0;
    end
    model_reset();

    // Power-on reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_value("rst_rvalid0", m0_rvalid, 1'b0);
    chk_value("rst_rvalid1", m1_rvalid, 1'b0);
    chk_value("rst_rdata0", m0_rdata, 16'h0000);
    chk_value("rst_rdata1", m1_rdata, 16'h0000);
    rst_n = 1'b1;

    // T1: reset asserted while an m0 read return is pending.
    set_req(0, 1'b0, 16'h0007, 16'h0000);
    #1 chk_value("t1_gnt0", m0_gnt, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    set_req(1, 1'b1, 16'h0003, 16'h1234);
    #1;
    chk_value("t1_rvalid0", m0_rvalid, 1'b0);
    chk_value("t1_rdata0", m0_rdata, 16'h0000);
    chk_value("t1_mem_load", mem_load, 1'b0);
    chk_value("t1_gnt0", m0_gnt, 1'b0);
    chk_value("t1_gnt1", m1_gnt, 1'b0);
    idle_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // T2: solo read returns BEEF one cycle later.
    set_req(0, 1'b0, 16'h0005, 16'h0000);
    step(win);
    chk_value("t2_rdata", m0_rdata, 16'hBEEF);
    chk_value("t2_rvalid", m0_rvalid, 1'b1);
    idle_reqs();
    step(win);

    // T3: solo write to the LED address, then read it back through m0.
    set_req(1, 1'b1, 16'd16384, 16'h001F);
    #1 chk_value("t3_load", mem_load, 1'b1);
    step(win);
    idle_reqs();
    step(win);
    set_req(0, 1'b0, 16'd16384, 16'h0000);
    step(win);
    chk_value("t3_readback", m0_rdata, 16'h001F);
    idle_reqs();
    step(win);

    // T4: continuous contention from IDLE alternates in bursts of MAXB.
    set_req(0, 1'b0, 16'h0001, 16'h0000);
    set_req(1, 1'b0, 16'h0002, 16'h0000);
    for (int i = 0; i < 4 * MAXB; i++) begin
      step(win);
      chk_value("t4_pattern", win, (i / MAXB) % 2);
    end
    idle_reqs();
    step(win);

    // T5: an idle cycle breaks m1's burst, so m0 wins the next contention.
    set_req(1, 1'b0, 16'h0004, 16'h0000);
    step(win);
    step(win);
    idle_reqs();
    step(win);
    set_req(0, 1'b0, 16'h0008, 16'h0000);
    set_req(1, 1'b0, 16'h0009, 16'h0000);
    step(win);
    chk_value("t5_first", win, 0);
    idle_reqs();
    step(win);

    // T6: m1 write waits out m0's burst and lands exactly once.
    wr10_cnt = 0;
    set_req(0, 1'b0, 16'h0011, 16'h0000);
    set_req(1, 1'b1, 16'h0010, 16'hA5A5);
    got_m1 = 0;
    for (int i = 0; i < 12 && got_m1 == 0; i++) begin
      step(win);
      if (win == 1) begin
        got_m1 = 1;
        req[1] = 1'b0;
      end else begin
        adr[0] = adr[0] + 16'd1;
      end
    end
    chk_value("t6_granted", got_m1, 1);
    step(win);
    idle_reqs();
    step(win);
    chk_value("t6_wr_count", wr10_cnt, 1);
    chk_value("t6_wr_data", wr10_val, 16'hA5A5);

    // Random traffic: requests are held until granted, then a new one may follow at once.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int x = 0; x < 2; x++) begin
        if (!req[x] && $urandom_range(0, 9) < 7) begin
          set_req(x, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0) ? 16'd16384 : 16'($urandom_range(0, 31)),
                  16'($urandom));
        end
      end
      step(win);
      if (win >= 0) req[win] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
